imem_responder: RTL and testbench

- Instruction-memory responder: serves the far end of the core's fetch interface.
- The fetch unit issues a word address; this block returns the 32-bit instruction after a programmable latency, using a valid/ready request/response handshake.
- Backing store is a word array preloaded through a separate load port (testbench or boot loader).
- Lets the core move from combinational fetch to a multi-cycle, stallable fetch.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_array.sv | 44 ++++
 rtl/imem_responder.sv | 138 +++++++++++++
 tb/tb_imem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state type for the instruction-memory responder
// Purpose: state encoding, default base address and array geometry used by
//          imem_responder and imem_array.
// Ports:   none (package).
package imem_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Byte address that maps to word 0 of the backing array
  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;

  // Default array geometry
  localparam int IMEM_DEPTH = 4096;
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_WAIT = WAIT,
    S_RESP = RESP
  } state_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word array with a load write port and a registered read port
// Purpose: backing store for imem_responder. Contents are never cleared; only
//          the read register is reset.
// Ports:   clk, rst (async active-low, read register only)
//          wen/waddr/wdata  synchronous write (load port)
//          ren/raddr        read request, data appears on rdata after the edge
//          rdata            registered read data, held while ren=0
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage has no reset so preloaded code survives a core reset.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Nonblocking read samples the pre-write contents, so a same-edge write
  // to the read index returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (ren) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction fetch responder with programmable latency
// Purpose: accepts one word-address fetch at a time, returns the stored word
//          (or an error) LATENCY edges after accept, counting the accept edge.
// Ports:   clk, rst (async active-low)
//          req_valid/req_ready/req_addr       fetch request handshake
//          resp_valid/resp_ready              response handshake
//          resp_data/resp_err                 response payload, stable until taken
//          ld_wen/ld_addr/ld_data             array load port, usable any time
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = IMEM_DEPTH,
  parameter logic [31:0] BASE       = IMEM_BASE,
  parameter int          LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_err,
  input  logic                     ld_wen,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic [AW-1:0]   idx_q;
  logic            err_q;
  logic            accept;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // Address decode of the incoming request; the result is captured at accept
  // so later changes of req_addr have no effect.
  logic [31:0]     offset;
  logic [31:0]     word;
  logic            addr_err;
  logic [AW-1:0]   req_idx;

  assign offset   = req_addr - BASE;
  assign word     = offset >> 2;
  assign req_idx  = word[AW-1:0];
  // addr < BASE catches the wrap-around of offset for low addresses
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) ||
                    (word >= 32'(DEPTH));

  assign accept = (state == S_IDLE) && req_valid;

  // With LATENCY==1 the read is issued on the accept edge itself, so the
  // index comes straight from the request instead of the captured copy.
  assign rd_addr = (state == S_IDLE) ? req_idx : idx_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_nxt = LAT_M1;
          if (LATENCY == 1) begin
            rd_en     = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        // Last wait cycle: read now so the word is registered as RESP begins.
        if (cnt == 4'd1) begin
          rd_en     = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q <= req_idx;
        err_q <= addr_err;
      end
    end
  end

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wen   (ld_wen),
    .waddr (ld_addr),
    .wdata (ld_data),
    .ren   (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // The read register only changes on rd_en, so payload is stable through
  // back-pressure; error responses force the data to zero.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q) ? rd_data : '0;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder (LATENCY 2 and 1)
module tb_imem_responder;

  localparam int          DEPTH = 4096;
  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic [31:0]     req_addr = 32'h0;
  logic            resp_ready = 1'b1;
  logic            ld_wen = 1'b0;
  logic [AW-1:0]   ld_addr = '0;
  logic [31:0]     ld_data = 32'h0;

  logic [1:0]      rq_rdy;
  logic [1:0]      rs_vld;
  logic [1:0]      rs_err;
  logic [1:0][31:0] rs_dat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rq_rdy[0]), .req_addr(req_addr),
    .resp_valid(rs_vld[0]), .resp_ready(resp_ready), .resp_data(rs_dat[0]), .resp_err(rs_err[0]),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rq_rdy[1]), .req_addr(req_addr),
    .resp_valid(rs_vld[1]), .resp_ready(resp_ready), .resp_data(rs_dat[1]), .resp_err(rs_err[1]),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data));

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit bad_addr(logic [31:0] a);
    longint la;
    longint lb;
    la = {32'b0, a};
    lb = {32'b0, BASE};
    return (a[1:0] != 2'b00) || (la < lb) || (la >= lb + 4 * DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding fetch per responder; the response is
  // due LATENCY-1 edges after the accept edge, and carries the memory word as
  // it stood just before that edge's load-port write.
  bit          m_out  [2];
  int          m_age  [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];
  int          m_idx  [2];
  logic [31:0] mem [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (m_out[i]) begin
          if (m_age[i] >= lat_of(i) - 1) begin
            if (resp_ready) m_out[i] = 1'b0;
          end else begin
            m_age[i]++;
            if (m_age[i] == lat_of(i) - 1) m_data[i] = mem[m_idx[i]];
          end
        end else if (req_valid) begin
          m_out[i] = 1'b1;
          m_age[i] = 0;
          m_err[i] = bad_addr(req_addr);
          m_idx[i] = m_err[i] ? 0 : int'((req_addr - BASE) >> 2);
          if (lat_of(i) == 1) m_data[i] = mem[m_idx[i]];
        end
      end
    end
    if (ld_wen) mem[ld_addr] = ld_data;
  end

  always @(negedge rst) begin
    for (int i = 0; i < 2; i++) m_out[i] = 1'b0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit exp_v;
      exp_v = m_out[i] && (m_age[i] >= lat_of(i) - 1);
      chk($sformatf("model_req_ready[L%0d]", lat_of(i)), 32'(rq_rdy[i]), 32'(!m_out[i]));
      chk($sformatf("model_resp_valid[L%0d]", lat_of(i)), 32'(rs_vld[i]), 32'(exp_v));
      if (exp_v || !rst) begin
        chk($sformatf("model_resp_data[L%0d]", lat_of(i)), rs_dat[i],
            (exp_v && !m_err[i]) ? m_data[i] : 32'h0);
        chk($sformatf("model_resp_err[L%0d]", lat_of(i)), 32'(rs_err[i]), 32'(exp_v && m_err[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rq_rdy != 2'b11 && n < 50) begin
      step();
      n++;
    end
    chk("idle_wait_timeout", 32'(rq_rdy == 2'b11), 32'h1);
  endtask

  // Single fetch with literal expectations for both latencies, resp_ready=1.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_d,
                       input logic exp_e, input bit collide);
    wait_idle();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = addr;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    if (collide) begin
      ld_wen  = 1'b1;
      ld_addr = AW'((addr - BASE) >> 2);
      ld_data = 32'hDEAD_BEEF;
    end
    chk("L1_valid_after_accept", 32'(rs_vld[1]), 32'h1);
    chk("L1_data", rs_dat[1], exp_d);
    chk("L1_err", 32'(rs_err[1]), 32'(exp_e));
    chk("L2_valid_early", 32'(rs_vld[0]), 32'h0);
    chk("L2_ready_busy1", 32'(rq_rdy[0]), 32'h0);
    step();
    ld_wen = 1'b0;
    chk("L2_valid", 32'(rs_vld[0]), 32'h1);
    chk("L2_data", rs_dat[0], exp_d);
    chk("L2_err", 32'(rs_err[0]), 32'(exp_e));
    chk("L2_ready_busy2", 32'(rq_rdy[0]), 32'h0);
    chk("L1_ready_back", 32'(rq_rdy[1]), 32'h1);
    step();
    chk("L2_ready_back", 32'(rq_rdy[0]), 32'h1);
    chk("L2_valid_done", 32'(rs_vld[0]), 32'h0);
  endtask

  initial begin
    #1 rst = 1'b0;
    step();
    step();
    chk("reset_ready", 32'(rq_rdy[0]), 32'h1);
    chk("reset_valid", 32'(rs_vld[0]), 32'h0);
    chk("reset_data", rs_dat[0], 32'h0);
    chk("reset_err", 32'(rs_err[0]), 32'h0);
    rst = 1'b1;
    step();

    // Preload words 0..63 and the last word
    for (int a = 0; a < 64; a++) begin
      ld_wen  = 1'b1;
      ld_addr = AW'(a);
      ld_data = (a == 0) ? 32'h0010_0093 : (a == 1) ? 32'h0000_0073 : $urandom;
      step();
    end
    ld_addr = AW'(DEPTH - 1);
    ld_data = 32'hCAFE_F00D;
    step();
    ld_wen = 1'b0;

    fetch(BASE,                 32'h0010_0093, 1'b0, 1'b0);
    fetch(BASE + 32'h4,         32'h0000_0073, 1'b0, 1'b0);
    fetch(BASE + 4 * DEPTH - 4, 32'hCAFE_F00D, 1'b0, 1'b0);
    fetch(BASE + 32'h2,         32'h0,         1'b1, 1'b0);
    fetch(32'h7FFF_FFFC,        32'h0,         1'b1, 1'b0);
    fetch(BASE + 4 * DEPTH,     32'h0,         1'b1, 1'b0);

    // Back-pressure on a fetch of word 1
    wait_idle();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = BASE + 32'h4;
    step();
    req_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rs_vld[0]), 32'h1);
      chk("bp_data", rs_dat[0], 32'h0000_0073);
      chk("bp_ready", 32'(rq_rdy[0]), 32'h0);
      chk("bp_L1_valid", 32'(rs_vld[1]), 32'h1);
      req_addr = $urandom;
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("bp_release_ready", 32'(rq_rdy[0]), 32'h1);
    chk("bp_release_valid", 32'(rs_vld[0]), 32'h0);

    // Load collision on the read edge: old word, then the new one
    fetch(BASE, 32'h0010_0093, 1'b0, 1'b1);
    fetch(BASE, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Asynchronous reset while the LATENCY=2 responder is waiting
    wait_idle();
    req_valid = 1'b1;
    req_addr  = BASE + 32'h4;
    step();
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(rq_rdy[0]), 32'h1);
    chk("rst_mid_valid", 32'(rs_vld[0]), 32'h0);
    chk("rst_mid_L1_valid", 32'(rs_vld[1]), 32'h0);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_no_spurious", 32'(rs_vld), 32'h0);
    end
    fetch(BASE + 32'h4, 32'h0000_0073, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: req_addr = BASE + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(1, 3));
        1: req_addr = BASE - 32'($urandom_range(1, 8) << 2);
        2: req_addr = BASE + 4 * DEPTH + 32'($urandom_range(0, 8) << 2);
        default: req_addr = BASE + 32'($urandom_range(0, 63) << 2);
      endcase
      resp_ready = ($urandom_range(0, 3) != 0);
      ld_wen     = ($urandom_range(0, 3) == 0);
      ld_addr    = AW'($urandom_range(0, 63));
      ld_data    = $urandom;
      step();
    end
    req_valid  = 1'b0;
    ld_wen     = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
